// File: rtl/intersection_pkg.sv
// Shared types for the intersection sequencer: phase encoding and lamp vectors.
package intersection_pkg;

    typedef enum logic [2:0] {
        PH_AR   = 3'd0,
        PH_NS_G = 3'd1,
        PH_NS_Y = 3'd2,
        PH_EW_G = 3'd3,
        PH_EW_Y = 3'd4,
        PH_WALK = 3'd5
    } phase_e;

    typedef struct packed {
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic ew_g;
        logic ew_y;
        logic ew_r;
        logic walk;
    } lamps_t;

    //                                     ns g y r  ew g y r  walk
    localparam lamps_t LAMPS_AR   = lamps_t'(7'b0_0_1__0_0_1__0);
    localparam lamps_t LAMPS_NS_G = lamps_t'(7'b1_0_0__0_0_1__0);
    localparam lamps_t LAMPS_NS_Y = lamps_t'(7'b0_1_0__0_0_1__0);
    localparam lamps_t LAMPS_EW_G = lamps_t'(7'b0_0_1__1_0_0__0);
    localparam lamps_t LAMPS_EW_Y = lamps_t'(7'b0_0_1__0_1_0__0);
    localparam lamps_t LAMPS_WALK = lamps_t'(7'b0_0_1__0_0_1__1);

    // Unused encodings fall back to all-red so no illegal code can show a green.
    function automatic lamps_t lamps_of(input phase_e ph);
        case (ph)
            PH_NS_G: lamps_of = LAMPS_NS_G;
            PH_NS_Y: lamps_of = LAMPS_NS_Y;
            PH_EW_G: lamps_of = LAMPS_EW_G;
            PH_EW_Y: lamps_of = LAMPS_EW_Y;
            PH_WALK: lamps_of = LAMPS_WALK;
            default: lamps_of = LAMPS_AR;
        endcase
    endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Saturating phase counter; advances on tick, flags the last tick of a timed phase.
module phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] last;

    assign last = limit - CNT_W'(1);
    assign done = tick && (count == last);

    // Clear on phase change, otherwise count ticks up to limit-1 and hold there.
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (tick && (count < last))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/intersection_controller.sv
// Actuated two-approach intersection sequencer with all-red clearance,
// latched vehicle/pedestrian demand and min/max green timing.
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned T_GREEN_MIN = 600,
    parameter int unsigned T_GREEN_MAX = 1200,
    parameter int unsigned T_YELLOW    = 200,
    parameter int unsigned T_ALL_RED   = 50,
    parameter int unsigned T_WALK      = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] L_GMAX   = CNT_W'(T_GREEN_MAX);
    localparam logic [CNT_W-1:0] L_YEL    = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] L_AR     = CNT_W'(T_ALL_RED);
    localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(T_GREEN_MAX - 1);

    phase_e           state, state_nx;
    logic             next_dir;   // 0 = NS next, 1 = EW next
    logic             walk_done;
    logic             dem_ns, dem_ew, ped_pend;
    logic [CNT_W-1:0] limit, count;
    logic             done, clr;
    logic             ns_go, ew_go;
    lamps_t           lamps;

    // Phase length for the timer; green uses the max so the counter saturates there.
    always_comb begin
        case (state)
            PH_NS_G, PH_EW_G: limit = L_GMAX;
            PH_NS_Y, PH_EW_Y: limit = L_YEL;
            PH_WALK:          limit = L_WALK;
            default:          limit = L_AR;
        endcase
    end

    assign clr = (state_nx != state);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick),
        .limit (limit),
        .count (count),
        .done  (done)
    );

    // Green ends only when someone is waiting: gap-out after min green, or forced at max.
    assign ns_go = tick && (dem_ew || ped_pend) &&
                   (((count >= GMIN_M1) && !car_ns) || (count >= GMAX_M1));
    assign ew_go = tick && (dem_ns || ped_pend) &&
                   (((count >= GMIN_M1) && !car_ew) || (count >= GMAX_M1));

    // Next-phase selection; every conflicting change passes through AR.
    always_comb begin
        state_nx = state;
        case (state)
            PH_AR: begin
                if (done) begin
                    if (ped_pend && !walk_done) state_nx = PH_WALK;
                    else if (next_dir)          state_nx = PH_EW_G;
                    else                        state_nx = PH_NS_G;
                end
            end
            PH_NS_G: if (ns_go) state_nx = PH_NS_Y;
            PH_NS_Y: if (done)  state_nx = PH_AR;
            PH_EW_G: if (ew_go) state_nx = PH_EW_Y;
            PH_EW_Y: if (done)  state_nx = PH_AR;
            PH_WALK: if (done)  state_nx = PH_AR;
            default:            state_nx = PH_AR;
        endcase
    end

    // State, direction/walk bookkeeping, demand latches (entry clear beats a same-cycle set).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PH_AR;
            next_dir  <= 1'b0;
            walk_done <= 1'b0;
            dem_ns    <= 1'b0;
            dem_ew    <= 1'b0;
            ped_pend  <= 1'b0;
            ped_ack   <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == PH_NS_Y && done) begin
                next_dir  <= 1'b1;
                walk_done <= 1'b0;
            end else if (state == PH_EW_Y && done) begin
                next_dir  <= 1'b0;
                walk_done <= 1'b0;
            end else if (state == PH_WALK && done) begin
                walk_done <= 1'b1;
            end

            if (state_nx == PH_NS_G && state != PH_NS_G) dem_ns <= 1'b0;
            else if (car_ns && state != PH_NS_G)         dem_ns <= 1'b1;

            if (state_nx == PH_EW_G && state != PH_EW_G) dem_ew <= 1'b0;
            else if (car_ew && state != PH_EW_G)         dem_ew <= 1'b1;

            if (state_nx == PH_WALK && state != PH_WALK) ped_pend <= 1'b0;
            else if (ped_req && state != PH_WALK)        ped_pend <= 1'b1;

            ped_ack <= (state_nx == PH_WALK) && (state != PH_WALK);
        end
    end

    // Moore lamp decode of the state register.
    always_comb begin
        lamps = lamps_of(state);
    end

    assign ns_g  = lamps.ns_g;
    assign ns_y  = lamps.ns_y;
    assign ns_r  = lamps.ns_r;
    assign ew_g  = lamps.ew_g;
    assign ew_y  = lamps.ew_y;
    assign ew_r  = lamps.ew_r;
    assign walk  = lamps.walk;
    assign phase = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench: table of per-cycle vectors plus hand-written ped/reset sequences.
module tb_intersection_controller;

    localparam logic [2:0] AR = 3'd0, NSG = 3'd1, NSY = 3'd2, EWG = 3'd3, EWY = 3'd4, WK = 3'd5;

    logic       clk = 1'b0;
    logic       reset, tick, car_ns, car_ew, ped_req;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;

    intersection_controller #(
        .CNT_W(32), .T_GREEN_MIN(4), .T_GREEN_MAX(8),
        .T_YELLOW(2), .T_ALL_RED(1), .T_WALK(3)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
        .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, cn, ce, pr;
        logic [2:0] ph;
        logic       ack;
        int         cnt;   // -1: don't check
        int         dem;   // expected dem_ew, -1: don't check
    } vec_t;

    vec_t tbl[$];

    // Expected lamps {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r,walk} for each phase.
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            NSG:     return 7'b1000010;
            NSY:     return 7'b0100010;
            EWG:     return 7'b0011000;
            EWY:     return 7'b0010100;
            WK:      return 7'b0010011;
            default: return 7'b0010010;
        endcase
    endfunction

    function automatic void v(input logic rst, cn, ce, pr, input logic [2:0] ph,
                              input logic ack, input int n = 1, input int cnt = -1,
                              input int dem = -1);
        vec_t e;
        e.rst = rst; e.cn = cn; e.ce = ce; e.pr = pr;
        e.ph = ph; e.ack = ack; e.cnt = -1; e.dem = -1;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin e.cnt = cnt; e.dem = dem; end
            tbl.push_back(e);
        end
    endfunction

    // Drive one cycle of inputs, clock it, compare 1 time unit after the edge.
    task automatic step(input string tag, input int idx, input logic rst, cn, ce, pr,
                        input logic [2:0] ph, input logic ack,
                        input int cnt = -1, input int dem = -1);
        logic [6:0] got;
        reset = rst; car_ns = cn; car_ew = ce; ped_req = pr;
        @(posedge clk);
        #1;
        got = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
        n_vec++;
        if (phase !== ph || got !== exp_lamps(ph) || ped_ack !== ack ||
            (cnt >= 0 && dut.count !== 32'(cnt)) ||
            (dem >= 0 && dut.dem_ew !== dem[0])) begin
            n_err++;
            $display("FAIL %s[%0d]: got phase=%0d lamps=%b ack=%b cnt=%0d dem_ew=%b; want phase=%0d lamps=%b ack=%b cnt=%0d dem_ew=%0d",
                     tag, idx, phase, got, ped_ack, dut.count, dut.dem_ew,
                     ph, exp_lamps(ph), ack, cnt, dem);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    initial begin
        tick = 1'b1;
        reset = 1'b1; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;

        // 1/2: reset, then NS green rests with saturated counter.
        v(1,0,0,0, AR, 0);
        v(0,0,0,0, NSG, 0, 50, 7);
        // 3: one-cycle EW car pulse while NS rests.
        v(0,0,1,0, NSG, 0);
        v(0,0,0,0, NSY, 0, 2);
        v(0,0,0,0, AR, 0);
        v(0,0,0,0, EWG, 0, 1, 0, 0);
        v(0,0,0,0, EWG, 0, 3);
        // 4a: both cars held from reset, green capped at max.
        v(1,1,1,0, AR, 0);
        v(0,1,1,0, NSG, 0, 8, 7);
        v(0,1,1,0, NSY, 0);
        // 4b: car_ns drops at green count 5 -> gap out after 6 cycles.
        v(1,1,1,0, AR, 0);
        v(0,1,1,0, NSG, 0, 6, 5);
        v(0,0,1,0, NSY, 0);

        for (int i = 0; i < tbl.size(); i++)
            step("table", i, tbl[i].rst, tbl[i].cn, tbl[i].ce, tbl[i].pr,
                 tbl[i].ph, tbl[i].ack, tbl[i].cnt, tbl[i].dem);

        // 5: ped request during NS green with EW demand; second press in WALK ignored.
        step("ped", 0, 1,0,0,0, AR, 0);
        step("ped", 1, 0,0,0,0, NSG, 0);
        step("ped", 2, 0,0,1,1, NSG, 0);
        step("ped", 3, 0,0,0,0, NSG, 0);
        step("ped", 4, 0,0,0,0, NSG, 0);
        step("ped", 5, 0,0,0,0, NSY, 0);
        step("ped", 6, 0,0,0,0, NSY, 0);
        step("ped", 7, 0,0,0,0, AR, 0);
        step("ped", 8, 0,0,0,0, WK, 1);
        step("ped", 9, 0,0,0,1, WK, 0);
        step("ped", 10, 0,0,0,0, WK, 0);
        step("ped", 11, 0,0,0,0, AR, 0);
        step("ped", 12, 0,0,0,0, EWG, 0, -1, 0);
        for (int i = 13; i < 19; i++)
            step("ped", i, 0,0,0,0, EWG, 0);
        check_bit("ped_pend_after_walk", dut.ped_pend, 1'b0);

        // 6: reset in 2nd NS_Y cycle with a pending ped request.
        step("rst", 0, 1,0,0,0, AR, 0);
        step("rst", 1, 0,0,0,0, NSG, 0);
        step("rst", 2, 0,0,0,1, NSG, 0);
        step("rst", 3, 0,0,0,0, NSG, 0);
        step("rst", 4, 0,0,0,0, NSG, 0);
        step("rst", 5, 0,0,0,0, NSY, 0);
        step("rst", 6, 0,0,0,0, NSY, 0);
        step("rst", 7, 1,0,0,0, AR, 0, 0);
        check_bit("ped_pend_after_reset", dut.ped_pend, 1'b0);
        for (int i = 8; i < 13; i++)
            step("rst", i, 0,0,0,0, NSG, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Actuated two-approach intersection sequencer. Drives a north-south (NS) and an east-west (EW) signal head, each with green, yellow and red, plus a shared pedestrian WALK phase.
- Inserts an all-red clearance between every conflicting phase. Serves latched vehicle and pedestrian demand, with min/max green timing.
- Sits above the per-head lamp drivers. All timing counts an external prescaled tick.

Parameters:
- CNT_W, 32, phase counter width; must hold T_GREEN_MAX-1.
- T_GREEN_MIN, 600, minimum green in ticks (>=1).
- T_GREEN_MAX, 1200, maximum green in ticks when the own approach keeps extending (>=T_GREEN_MIN).
- T_YELLOW, 200, yellow duration in ticks (>=1).
- T_ALL_RED, 50, all-red clearance in ticks (>=1).
- T_WALK, 400, pedestrian WALK duration in ticks (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle timing strobe; the counter advances only when tick=1.
- car_ns  in  1  NS vehicle sensor, level.
- car_ew  in  1  EW vehicle sensor, level.
- ped_req  in  1  pedestrian button, pulse or level.
- ns_g, ns_y, ns_r  out  1 each  NS lamps, one-hot.
- ew_g, ew_y, ew_r  out  1 each  EW lamps, one-hot.
- walk  out  1  pedestrian WALK lamp.
- ped_ack  out  1  one-cycle pulse on the first cycle of WALK.
- phase  out  3  current state encoding, for debug.

Behaviour:
- States: AR (all red), NS_G, NS_Y, EW_G, EW_Y, WALK.
- Auxiliary regs: next_dir (0=NS, 1=EW), walk_done, dem_ns, dem_ew, ped_pend.
- Outputs are a Moore decode of the state register.
  - Red is on for every state in which that approach is not green or yellow.
  - walk=1 only in WALK.
  - No state ever drives both approaches non-red.
- Reset, any cycle including mid-phase:
  - State=AR, next_dir=NS, walk_done=0, counter=0, all latches cleared.
  - Outputs next cycle: ns_r=ew_r=1, all others 0.
- Phase timer:
  - Counter clears on every state change.
  - On tick it increments, saturating at the current limit-1.
  - A "timed-T exit" fires on a cycle where tick=1 and counter==T-1, so a phase lasts exactly T ticks.
- Demand latches:
  - dem_ns sets while car_ns=1 and state!=NS_G; it clears on entry to NS_G. dem_ew mirrors this for EW.
  - ped_pend sets on ped_req=1 in any state except WALK, and clears on entry to WALK.
  - If a set and a clear occur in the same cycle, the clear wins (the request counts as served).
- NS_G (EW_G symmetric, with the sensors and latches swapped):
  - Exits to NS_Y on a tick when opposing demand (dem_ew | ped_pend) holds and either:
    - counter>=T_GREEN_MIN-1 and car_ns=0, or
    - counter>=T_GREEN_MAX-1.
  - With no opposing demand the block rests in green indefinitely; the counter saturates at T_GREEN_MAX-1.
- NS_Y: timed-T_YELLOW exit to AR, setting next_dir=EW and walk_done=0. EW_Y mirrors this with next_dir=NS.
- AR: on a timed-T_ALL_RED exit:
  - if ped_pend && !walk_done, go to WALK;
  - else go to NS_G if next_dir=NS, or EW_G if next_dir=EW.
- WALK: timed-T_WALK exit to AR with walk_done=1. ped_ack=1 on the cycle the state register first shows WALK.
- After reset, the first AR always leads to NS_G, or to WALK first if ped_req arrived during it.
- tick=0 freezes all timing; demand latching continues.

Decomposition:
- Package intersection_pkg holds:
  - the phase state enum and its 3-bit encoding (AR=0, NS_G=1, NS_Y=2, EW_G=3, EW_Y=4, WALK=5);
  - the lamp-vector constants.
- Sub-module phase_timer (CNT_W):
  - inputs clr, tick, limit;
  - outputs count and done (tick && count==limit-1);
  - saturating.
- The FSM, the latches and the output decode stay in intersection_controller.

Test Plan:
All tests use T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALL_RED=1, T_WALK=3, tick tied to 1.
1. Release reset, no inputs -> AR for 1 cycle, then ns_g=1 from cycle 1; ew_r=1 and walk=0 throughout.
2. No demand for 50 cycles -> ns_g stays 1 throughout, counter saturated at 7, no yellow.
3. NS resting, one-cycle car_ew pulse at cycle 20, car_ns=0 -> ns_y on the next 2 cycles, then 1 cycle all red, then ew_g=1; dem_ew cleared on EW_G entry.
4. car_ew and car_ns both held high from reset -> NS green for exactly 8 cycles (max cap); car_ns dropped at green count 5 -> green ends after 6 cycles.
5. During NS_G, with car_ew=1, pulse ped_req -> NS_Y(2), AR(1), WALK(3) with ped_ack for 1 cycle, AR(1), then EW_G; a second ped_req during WALK is ignored.
6. Assert reset on the 2nd cycle of NS_Y with ped_pend=1 -> next cycle all red, walk=0, latches cleared; after release the sequence is AR -> NS_G with no WALK.
